// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename/commit port bundle for the physical register free list
interface free_list_if #(
    parameter int PHY_REG_NUM  = 64,
    parameter int DECODE_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2
);
    localparam int PW = $clog2(PHY_REG_NUM);

    logic                              alloc_valid_i;
    logic [DECODE_WIDTH-1:0]           alloc_req_i;
    logic                              alloc_ready_o;
    logic [DECODE_WIDTH-1:0][PW-1:0]   preg_o;
    logic [COMMIT_WIDTH-1:0]           commit_valid_i;
    logic [COMMIT_WIDTH-1:0]           commit_alloc_i;
    logic [COMMIT_WIDTH-1:0]           commit_free_i;
    logic [COMMIT_WIDTH-1:0][PW-1:0]   commit_old_preg_i;
    logic                              restore_i;
    logic [PW:0]                       free_cnt_o;

    modport master (
        output alloc_valid_i, alloc_req_i, commit_valid_i, commit_alloc_i,
               commit_free_i, commit_old_preg_i, restore_i,
        input  alloc_ready_o, preg_o, free_cnt_o
    );

    modport slave (
        input  alloc_valid_i, alloc_req_i, commit_valid_i, commit_alloc_i,
               commit_free_i, commit_old_preg_i, restore_i,
        output alloc_ready_o, preg_o, free_cnt_o
    );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free physical register queue with committed-head restore
module free_list #(
    parameter int PHY_REG_NUM  = 64,
    parameter int DECODE_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave fl
);
    localparam int PW = $clog2(PHY_REG_NUM);
    localparam logic [PW:0] NUM = (PW+1)'(PHY_REG_NUM);

    logic [PW-1:0] queue [PHY_REG_NUM];
    logic [PW:0]   head, arch_head, tail;
    logic [PW:0]   head_n, arch_head_n, tail_n;
    logic [PW:0]   count, req_cnt, free_num, commit_num;
    logic [PW:0]   alloc_ofs [DECODE_WIDTH];
    logic [PW:0]   free_ofs  [COMMIT_WIDTH];
    logic          fire;
    logic [PW+1:0] fill_after_free;
    logic [PW:0]   spec_after;

    // Pointers carry a wrap bit, so the difference is the occupancy 0..N
    assign count         = tail - head;
    assign fl.free_cnt_o = count;

    // Compaction offsets: each requesting slot takes the next free entry,
    // each releasing commit slot takes the next tail position
    always_comb begin
        req_cnt    = '0;
        free_num   = '0;
        commit_num = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            alloc_ofs[i] = req_cnt;
            req_cnt      = req_cnt + (PW+1)'(fl.alloc_req_i[i]);
        end
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            free_ofs[c] = free_num;
            free_num    = free_num + (PW+1)'(fl.commit_valid_i[c] & fl.commit_free_i[c]);
            commit_num  = commit_num + (PW+1)'(fl.commit_valid_i[c] & fl.commit_alloc_i[c]);
        end
    end

    // Zero-latency read of the register each slot would be handed
    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            fl.preg_o[i] = queue[PW'(head + alloc_ofs[i])];
        end
    end

    // Readiness uses registered occupancy only; same-cycle frees are not bypassed
    assign fl.alloc_ready_o = (count >= req_cnt);
    assign fire             = fl.alloc_valid_i & fl.alloc_ready_o & ~fl.restore_i;

    // Next pointers; a flush rewinds head to the committed head including this cycle's commits
    always_comb begin
        arch_head_n = arch_head + commit_num;
        tail_n      = tail + free_num;
        if (fl.restore_i)
            head_n = arch_head_n;
        else if (fire)
            head_n = head + req_cnt;
        else
            head_n = head;
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            arch_head <= '0;
            tail      <= NUM;
        end else begin
            head      <= head_n;
            arch_head <= arch_head_n;
            tail      <= tail_n;
        end
    end

    // Queue storage: identity map on reset, released registers appended at tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PHY_REG_NUM; k++)
                queue[k] <= PW'(k);
        end else begin
            for (int c = 0; c < COMMIT_WIDTH; c++)
                if (fl.commit_valid_i[c] & fl.commit_free_i[c])
                    queue[PW'(tail + free_ofs[c])] <= fl.commit_old_preg_i[c];
        end
    end

    assign fill_after_free = {1'b0, count} + {1'b0, free_num};
    assign spec_after      = head_n - arch_head_n;

    // Guard against releasing more registers than fit and commits overrunning allocation
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fill_after_free <= {1'b0, NUM});
            assert (spec_after <= NUM);
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list against a list model
module tb_free_list;
    localparam int N  = 64;
    localparam int DW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Model: ordered free list plus allocated-but-uncommitted registers
    int m_fl[$];
    int m_spec[$];

    always #5 clk = ~clk;

    free_list_if #(.PHY_REG_NUM(N), .DECODE_WIDTH(DW), .COMMIT_WIDTH(CW)) fl_if ();

    free_list #(.PHY_REG_NUM(N), .DECODE_WIDTH(DW), .COMMIT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    function automatic int pc(input logic [DW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DW; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs presented in that cycle
    always @(posedge clk) begin
        if (rst) begin
            m_fl   = {};
            m_spec = {};
            for (int k = 0; k < N; k++) m_fl.push_back(k);
        end else begin
            if (fl_if.alloc_valid_i && !fl_if.restore_i &&
                m_fl.size() >= pc(fl_if.alloc_req_i)) begin
                for (int i = 0; i < DW; i++)
                    if (fl_if.alloc_req_i[i] && m_fl.size() > 0)
                        m_spec.push_back(m_fl.pop_front());
            end
            for (int c = 0; c < CW; c++)
                if (fl_if.commit_valid_i[c] && fl_if.commit_alloc_i[c] && m_spec.size() > 0)
                    void'(m_spec.pop_front());
            if (fl_if.restore_i)
                while (m_spec.size() > 0) m_fl.push_front(m_spec.pop_back());
            for (int c = 0; c < CW; c++)
                if (fl_if.commit_valid_i[c] && fl_if.commit_free_i[c])
                    m_fl.push_back(int'(fl_if.commit_old_preg_i[c]));
        end
    end

    // Every-cycle comparison of the DUT outputs against the model
    always @(negedge clk) begin
        int n;
        int p;
        if (!rst) begin
            n = pc(fl_if.alloc_req_i);
            chk("free_cnt", 32'(fl_if.free_cnt_o), 32'(m_fl.size()));
            chk("alloc_ready", 32'(fl_if.alloc_ready_o), 32'(m_fl.size() >= n));
            p = 0;
            for (int i = 0; i < DW; i++) begin
                if (fl_if.alloc_req_i[i]) begin
                    if (p < m_fl.size())
                        chk($sformatf("preg_slot%0d", i), 32'(fl_if.preg_o[i]), 32'(m_fl[p]));
                    p++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] rq, input logic [1:0] cv,
                         input logic [1:0] ca, input logic [1:0] cf,
                         input logic [5:0] o0, input logic [5:0] o1, input logic rs);
        fl_if.alloc_valid_i        = v;
        fl_if.alloc_req_i          = rq;
        fl_if.commit_valid_i       = cv;
        fl_if.commit_alloc_i       = ca;
        fl_if.commit_free_i        = cf;
        fl_if.commit_old_preg_i[0] = o0;
        fl_if.commit_old_preg_i[1] = o1;
        fl_if.restore_i            = rs;
    endtask

    // One cycle: apply inputs just after the edge, return at the falling edge
    task automatic cyc(input logic v, input logic [1:0] rq, input logic [1:0] cv,
                       input logic [1:0] ca, input logic [1:0] cf,
                       input logic [5:0] o0, input logic [5:0] o1, input logic rs);
        @(posedge clk);
        #1;
        drive(v, rq, cv, ca, cf, o0, o1, rs);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_free_cnt", 32'(fl_if.free_cnt_o), 32'd64);
        chk("reset_ready", 32'(fl_if.alloc_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] o0, o1;
        rst = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        do_reset();

        // Three back-to-back pair allocations from reset
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("p1_cnt", 32'(fl_if.free_cnt_o), 32'd64);
        chk("p1_s0", 32'(fl_if.preg_o[0]), 32'd0);
        chk("p1_s1", 32'(fl_if.preg_o[1]), 32'd1);
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("p2_cnt", 32'(fl_if.free_cnt_o), 32'd62);
        chk("p2_s0", 32'(fl_if.preg_o[0]), 32'd2);
        chk("p2_s1", 32'(fl_if.preg_o[1]), 32'd3);
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("p3_cnt", 32'(fl_if.free_cnt_o), 32'd60);
        chk("p3_s0", 32'(fl_if.preg_o[0]), 32'd4);
        chk("p3_s1", 32'(fl_if.preg_o[1]), 32'd5);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("p4_cnt", 32'(fl_if.free_cnt_o), 32'd58);

        // Compaction onto the upper slot only
        do_reset();
        cyc(1, 2'b10, 0, 0, 0, 0, 0, 0);
        chk("cmp_s1", 32'(fl_if.preg_o[1]), 32'd0);
        cyc(1, 2'b01, 0, 0, 0, 0, 0, 0);
        chk("cmp_s0", 32'(fl_if.preg_o[0]), 32'd1);
        chk("cmp_cnt", 32'(fl_if.free_cnt_o), 32'd63);

        // Drain to empty, then release two registers
        for (int i = 0; i < 31; i++) cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        cyc(1, 2'b01, 0, 0, 0, 0, 0, 0);
        chk("empty_cnt", 32'(fl_if.free_cnt_o), 32'd0);
        chk("empty_ready_req", 32'(fl_if.alloc_ready_o), 32'd0);
        cyc(1, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("empty_ready_noreq", 32'(fl_if.alloc_ready_o), 32'd1);
        cyc(0, 2'b00, 2'b11, 2'b00, 2'b11, 6'd7, 6'd9, 0);
        chk("free_same_cycle_cnt", 32'(fl_if.free_cnt_o), 32'd0);
        cyc(0, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("freed_cnt", 32'(fl_if.free_cnt_o), 32'd2);
        chk("freed_s0", 32'(fl_if.preg_o[0]), 32'd7);
        chk("freed_s1", 32'(fl_if.preg_o[1]), 32'd9);

        // Allocate 10, commit 4, flush (with an ignored same-cycle fire)
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        cyc(0, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 0);
        cyc(0, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 0);
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 1);
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("restore_cnt", 32'(fl_if.free_cnt_o), 32'd60);
        chk("restore_s0", 32'(fl_if.preg_o[0]), 32'd4);
        chk("restore_s1", 32'(fl_if.preg_o[1]), 32'd5);

        // Flush together with one commit and the release of register 3
        cyc(0, 2'b00, 2'b01, 2'b01, 2'b01, 6'd3, 6'd0, 1);
        chk("combo_pre_cnt", 32'(fl_if.free_cnt_o), 32'd58);
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("combo_cnt", 32'(fl_if.free_cnt_o), 32'd60);
        chk("combo_s0", 32'(fl_if.preg_o[0]), 32'd5);
        chk("combo_s1", 32'(fl_if.preg_o[1]), 32'd6);

        // Steady alloc/commit/free pairs that carry both pointers across the wrap
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            o0 = 6'(m_spec.size() > 0 ? m_spec[0] : 0);
            o1 = 6'(m_spec.size() > 1 ? m_spec[1] : 0);
            drive(1'b1, 2'b11, 2'b11, 2'b11, 2'b11, o0, o1, 1'b0);
            @(negedge clk);
        end
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("wrap_cnt", 32'(fl_if.free_cnt_o), 32'd58);

        // Asynchronous reset in the middle of an active cycle
        @(posedge clk);
        #1;
        drive(1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 6'd1, 6'd2, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", 32'(fl_if.free_cnt_o), 32'd64);
        chk("async_rst_s0", 32'(fl_if.preg_o[0]), 32'd0);
        chk("async_rst_s1", 32'(fl_if.preg_o[1]), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        rst = 1'b0;
        cyc(1, 2'b11, 0, 0, 0, 0, 0, 0);
        chk("post_rst_cnt", 32'(fl_if.free_cnt_o), 32'd64);
        chk("post_rst_s0", 32'(fl_if.preg_o[0]), 32'd0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("post_rst_cnt2", 32'(fl_if.free_cnt_o), 32'd62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular free-physical-register queue that feeds the rename stage.
- Each cycle it hands up to DECODE_WIDTH free physical register numbers to the register alias table (its preg_i), compacted onto the requesting slots.
- Retires old physical destinations pushed back by commit.
- Keeps a committed head pointer so a flush (restore_i) recovers the non-speculative free set in one cycle, in lockstep with the alias-table restore.

Parameters:
- PHY_REG_NUM, 64, number of physical registers; power of two, at least 2*DECODE_WIDTH.
- DECODE_WIDTH, 2, rename slots per cycle; equals the codebase DECODE_WIDTH.
- COMMIT_WIDTH, 2, commit slots per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid_i  in  1  rename group valid; group fires when alloc_valid_i & alloc_ready_o.
- alloc_req_i  in  DECODE_WIDTH  per-slot destination request (dest_valid); any bit pattern allowed.
- alloc_ready_o  out  1  free count >= popcount(alloc_req_i).
- preg_o  out  DECODE_WIDTH x log2(PHY_REG_NUM)  allocated physical register per slot.
- commit_valid_i  in  COMMIT_WIDTH  committing instruction per slot, compacted from slot 0.
- commit_alloc_i  in  COMMIT_WIDTH  committing instruction had allocated a dest.
- commit_free_i  in  COMMIT_WIDTH  committing instruction releases an old pdest (ppdst_valid).
- commit_old_preg_i  in  COMMIT_WIDTH x log2(PHY_REG_NUM)  released physical register.
- restore_i  in  1  flush; revert speculative allocations.
- free_cnt_o  out  log2(PHY_REG_NUM)+1  current free entries (registered).

Behaviour:
- Storage: queue[PHY_REG_NUM] of register numbers.
- Pointers head, arch_head and tail are each log2(N)+1 bits, with the MSB as wrap bit; index = low bits.
- count = tail - head, in the range 0..N.
- Reset (async, rst=1):
  - queue[k] = k.
  - head = arch_head = 0.
  - tail = N (wrap bit set, index 0).
  - Outputs: free_cnt_o = N; alloc_ready_o = 1 whenever popcount(req) <= N; preg_o[i] = queue[prefix(i)] (all 0 with req = 0).
- Allocation (combinational from registered state):
  - prefix(i) = popcount(alloc_req_i[i-1:0]).
  - preg_o[i] = queue[(head + prefix(i)) mod N] for every slot; values on non-requested slots are don't-care but deterministic.
  - Zero latency: preg_o is valid in the same cycle alloc_valid_i is presented.
- Fire:
  - head_n = head + popcount(alloc_req_i).
  - If not fired, head holds; preg_o stays stable while state is unchanged.
- alloc_ready_o uses the registered count only. Entries freed this cycle are not allocatable until the next cycle (no bypass).
- Free:
  - For each commit slot c with commit_valid_i[c] & commit_free_i[c], write queue[tail + prefix_free(c)] = commit_old_preg_i[c].
  - tail_n = tail + popcount(valid & free).
- Commit advance: arch_head_n = arch_head + popcount(commit_valid_i & commit_alloc_i).
- Restore:
  - restore_i has priority over allocation; the fire is ignored.
  - head_n = arch_head_n, i.e. includes same-cycle commit advance.
  - Same-cycle frees are still applied, since commits are older than the flush.
  - Next-cycle count = tail_n - arch_head_n.
- Wrap-around: pointers increment modulo 2N; physical index modulo N. Multi-entry alloc/free straddling index N-1 -> 0 must be correct.
- Full/empty:
  - count never exceeds N by construction.
  - Assertion fires on free overflow (count + frees > N) or arch_head passing head.
  - count = 0 -> alloc_ready_o = 0 for any nonzero request; alloc_ready_o = 1 when alloc_req_i = 0.
- Reset mid-operation: all state returns to reset values immediately, regardless of in-flight fire or commit.
- free_cnt_o = registered count; updates the cycle after fire, free or restore.

Test Plan:
- Reset, req=2'b11, valid=1 for 3 cycles -> preg_o pairs (0,1), (2,3), (4,5); free_cnt_o 64 -> 62 -> 60 -> 58.
- req=2'b10 after reset -> preg_o[1]=0; head advances by 1; next cycle req=2'b01 gives preg_o[0]=1.
- Allocate all 64 -> free_cnt_o=0, alloc_ready_o=0 for req=2'b01, ready=1 for req=0. Then commit_free slots 0,1 with old 7,9 -> next cycle count=2, preg_o=(7,9).
- Allocate 10, commit_alloc 4, restore_i -> head=4, free_cnt_o=60; the next allocation returns 4,5.
- Same cycle: restore_i, commit_alloc 1, commit_free of reg 3 -> head = arch_head+1, tail+1, reg 3 appended.
- Pointer wrap: cycle alloc/free pairs 40 times -> allocations read across index 63->0 in order; count unchanged; no assertions fire.
